// File: rtl/writeback_unit.sv
// Write-side master for the register file: merges ALU and load results through
// an in-order FIFO into one registered write port and tracks pending writes.
module writeback_unit #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_rd,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         write_data,
  output logic                      reg_write,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  output logic                      issue_ok,
  output logic [(2**ADDR_W)-1:0]    busy,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic [CNT_W-1:0]  free_c;
  logic [CNT_W-1:0]  push_cnt_c;
  logic [PTR_W-1:0]  alu_ptr_c;
  logic              mem_fire_c, alu_fire_c, pop_c;
  entry_t            head_c;

  // Readies from registered occupancy only; memory gets the last free slot.
  always_comb begin
    free_c    = CNT_W'(DEPTH) - count_q;
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (!rst) begin
      mem_ready = (free_c >= CNT_W'(1));
      alu_ready = (free_c >= CNT_W'(2)) || ((free_c == CNT_W'(1)) && !mem_valid);
    end
    issue_ok = !busy_q[issue_rd];
  end

  // Push/pop bookkeeping and next values for the write port and scoreboard.
  always_comb begin
    mem_fire_c = mem_valid && mem_ready;
    alu_fire_c = alu_valid && alu_ready;
    pop_c      = (count_q != '0);
    push_cnt_c = CNT_W'(mem_fire_c) + CNT_W'(alu_fire_c);
    alu_ptr_c  = mem_fire_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    head_c     = fifo_q[rd_ptr_q];

    wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    count_d  = count_q + push_cnt_c - CNT_W'(pop_c);

    we_d    = pop_c;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    if (pop_c) begin
      rd_d    = head_c.rd;
      wdata_d = head_c.data;
    end

    // Clear applies first so a same-edge issue of the same register wins.
    busy_d = busy_q;
    if (we_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_valid && issue_ok) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  // FIFO storage: older (memory) entry lands first when both sources fire.
  always_ff @(posedge clk) begin
    if (mem_fire_c) begin
      fifo_q[wr_ptr_q] <= '{rd: mem_rd, data: mem_data};
    end
    if (alu_fire_c) begin
      fifo_q[alu_ptr_c] <= '{rd: alu_rd, data: alu_data};
    end
  end

  // Control state, write port and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
    end
  end

  assign rd         = rd_q;
  assign write_data = wdata_q;
  assign reg_write  = we_q;
  assign busy       = busy_q;
  assign count      = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomised and directed bench for writeback_unit against a queue-based model.
module tb_writeback_unit;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREG   = 8;
  localparam int unsigned CW     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, alu_ready, mem_valid, mem_ready;
  logic [ADDR_W-1:0] alu_rd, mem_rd, rd, issue_rd;
  logic [DATA_W-1:0] alu_data, mem_data, write_data;
  logic              reg_write, issue_valid, issue_ok;
  logic [NREG-1:0]   busy;
  logic [CW-1:0]     count;

  writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rd(rd), .write_data(write_data), .reg_write(reg_write),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(issue_ok),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
  } ent_t;

  // Model: queue of accepted results plus the expected write port and busy map.
  ent_t              q[$];
  logic [ADDR_W-1:0] e_rd;
  logic [DATA_W-1:0] e_wd;
  logic              e_we;
  logic [NREG-1:0]   e_busy;

  int   n_chk = 0;
  int   n_fail = 0;
  logic s_ar, s_mr, s_ok;
  logic last_mf, last_af;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    e_rd = '0; e_wd = '0; e_we = 1'b0; e_busy = '0;
  endtask

  task automatic set_in(input logic mv, input logic [2:0] mrd, input logic [7:0] md,
                        input logic av, input logic [2:0] ard, input logic [7:0] ad,
                        input logic iv, input logic [2:0] ird);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    issue_valid = iv; issue_rd = ird;
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registers.
  task automatic step();
    int   free;
    logic m_r, a_r, ok, mf, af;
    ent_t e;
    #1;
    free = int'(DEPTH) - q.size();
    m_r  = (free >= 1);
    a_r  = (free >= 2) || (free == 1 && !mem_valid);
    ok   = !e_busy[issue_rd];
    chk("mem_ready", 32'(mem_ready), 32'(m_r));
    chk("alu_ready", 32'(alu_ready), 32'(a_r));
    chk("issue_ok", 32'(issue_ok), 32'(ok));
    s_ar = alu_ready; s_mr = mem_ready; s_ok = issue_ok;
    mf = mem_valid && m_r;
    af = alu_valid && a_r;
    @(posedge clk);
    if (e_we) e_busy[e_rd] = 1'b0;
    if (issue_valid && ok) e_busy[issue_rd] = 1'b1;
    if (q.size() != 0) begin
      e = q.pop_front();
      e_rd = e.rd; e_wd = e.d; e_we = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    if (mf) q.push_back('{rd: mem_rd, d: mem_data});
    if (af) q.push_back('{rd: alu_rd, d: alu_data});
    last_mf = mf; last_af = af;
    #1;
    chk("reg_write", 32'(reg_write), 32'(e_we));
    chk("rd", 32'(rd), 32'(e_rd));
    chk("write_data", 32'(write_data), 32'(e_wd));
    chk("count", 32'(count), 32'(q.size()));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  logic [7:0] ad, md;
  logic [2:0] ard;
  int         dens;

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    last_mf = 1'b0; last_af = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_we", 32'(reg_write), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    #2 rst = 1'b0;

    // 1: single ALU push commits two edges after acceptance
    set_in(0, 0, 0, 1, 3'd2, 8'h1E, 0, 0); step();
    chk("t1_count1", 32'(count), 32'd1);
    chk("t1_we0", 32'(reg_write), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t1_we", 32'(reg_write), 32'd1);
    chk("t1_rd", 32'(rd), 32'd2);
    chk("t1_wd", 32'(write_data), 32'h1E);
    step();
    chk("t1_we_off", 32'(reg_write), 32'd0);
    chk("t1_count0", 32'(count), 32'd0);

    // 2: same-cycle mem and ALU, memory commits first
    set_in(1, 3'd3, 8'hAA, 1, 3'd4, 8'h55, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t2_rd_a", 32'(rd), 32'd3);
    chk("t2_wd_a", 32'(write_data), 32'hAA);
    step();
    chk("t2_rd_b", 32'(rd), 32'd4);
    chk("t2_wd_b", 32'(write_data), 32'h55);
    chk("t2_we_b", 32'(reg_write), 32'd1);
    step();

    // 3: both sources streaming; count 0,2,3,3 and ALU stalls at DEPTH-1
    md = 8'h40; ad = 8'h80;
    set_in(1, 3'd1, md, 1, 3'd6, ad, 0, 0); step();
    chk("t3_count2", 32'(count), 32'd2);
    md++; ad++;
    set_in(1, 3'd1, md, 1, 3'd6, ad, 0, 0); step();
    chk("t3_count3", 32'(count), 32'd3);
    md++; ad++;
    set_in(1, 3'd1, md, 1, 3'd6, ad, 0, 0); step();
    chk("t3_alu_stall", 32'(s_ar), 32'd0);
    chk("t3_count3b", 32'(count), 32'd3);
    md++;
    set_in(0, 3'd1, md, 1, 3'd6, ad, 0, 0); step();
    chk("t3_alu_go", 32'(s_ar), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();
    chk("t3_drained", 32'(count), 32'd0);

    // 4: scoreboard set by issue, cleared by the commit edge
    set_in(0, 0, 0, 0, 0, 0, 1, 3'd5); step();
    chk("t4_busy_set", 32'(busy[5]), 32'd1);
    step();
    chk("t4_issue_blocked", 32'(s_ok), 32'd0);
    set_in(0, 0, 0, 1, 3'd5, 8'h5A, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t4_we_rd5", 32'(rd), 32'd5);
    chk("t4_busy_held", 32'(busy[5]), 32'd1);
    step();
    chk("t4_busy_clr", 32'(busy[5]), 32'd0);

    // 5: untracked commit and issue of the same register on one edge: set wins
    set_in(0, 0, 0, 1, 3'd1, 8'h11, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 3'd1); step();
    chk("t5_busy", 32'(busy), 32'h02);

    // 6: async reset with count=3 and busy=0x28
    set_in(0, 0, 0, 1, 3'd1, 8'h12, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 3'd3); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 3'd5); step();
    set_in(1, 3'd0, 8'h10, 1, 3'd2, 8'h20, 0, 0); step();
    set_in(1, 3'd4, 8'h30, 1, 3'd6, 8'h40, 0, 0); step();
    chk("t6_count3", 32'(count), 32'd3);
    chk("t6_busy28", 32'(busy), 32'h28);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_we", 32'(reg_write), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("t6_rst_alu_ready", 32'(alu_ready), 32'd0);
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    set_in(0, 0, 0, 1, 3'd7, 8'h77, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("t6_post_rd", 32'(rd), 32'd7);
    chk("t6_post_wd", 32'(write_data), 32'h77);
    step();
    chk("t6_post_idle", 32'(reg_write), 32'd0);
    chk("t6_post_count", 32'(count), 32'd0);

    // Random traffic with held payloads on stall and random issue claims
    last_mf = 1'b0; last_af = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) dens = int'($urandom_range(1, 4));
      if (!(mem_valid && !last_mf)) begin
        mem_valid = ($urandom_range(0, 4) < dens);
        mem_rd    = 3'($urandom);
        mem_data  = 8'($urandom);
      end
      if (!(alu_valid && !last_af)) begin
        alu_valid = ($urandom_range(0, 4) < dens);
        ard       = 3'($urandom);
        alu_rd    = ard;
        alu_data  = 8'($urandom);
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 3'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side master for the 8-entry, 8-bit register file: drives its rd / write_data / reg_write port.
- Merges results from two producers into the single register-file write port through an in-order FIFO:
  - ALU: single-cycle results.
  - Memory/load unit: multi-cycle results.
- Keeps a per-register pending-write scoreboard for issue-stage hazard checks.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
DATA_W, 8, register data width
ADDR_W, 3, register index width (2**ADDR_W registers)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle when alu_valid also high
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result available
mem_ready  out  1  load result accepted this cycle when mem_valid also high
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load result
rd  out  ADDR_W  register-file write index (registered)
write_data  out  DATA_W  register-file write data (registered)
reg_write  out  1  register-file write enable (registered)
issue_valid  in  1  issue stage claims issue_rd as a pending destination
issue_rd  in  ADDR_W  destination being claimed
issue_ok  out  1  combinational: busy[issue_rd]==0
busy  out  2**ADDR_W  pending-write bit per register
count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, immediate on rst rising):
  - FIFO emptied; count=0; reg_write=0; rd=0; write_data=0; busy=0.
  - alu_ready=0 and mem_ready=0 while rst is high.
  - Entries in flight are discarded.
- Free slots: free = DEPTH - count, using registered count only. A pop in the same cycle is not credited.
- Readies (combinational):
  - mem_ready = (free>=1).
  - alu_ready = (free>=2) or (free==1 and !mem_valid).
  - Memory has priority; alu_ready depends on mem_valid.
- Source handshake: a source holding valid without ready must keep rd/data stable. valid-low cycles are ignored.
- Push:
  - mem_fire = mem_valid & mem_ready; alu_fire = alu_valid & alu_ready.
  - Both firing: mem entry written first (older), ALU entry second.
  - Count grows by the number of pushes.
- Pop:
  - At each edge where registered count!=0, the head moves into rd/write_data and reg_write=1 for the following cycle.
  - If count==0, reg_write=0 and rd/write_data hold their last values.
  - One pop per cycle maximum; the count update is pushes minus pop.
- Latency:
  - A push accepted into an empty FIFO at edge N appears on reg_write/rd/write_data after edge N+1.
  - The register file captures it at edge N+2.
- Ordering: strict FIFO. Commit order equals acceptance order, including repeated writes to the same register.
- Scoreboard:
  - Set: at an edge with issue_valid & issue_ok, busy[issue_rd] is set.
  - Clear: at an edge with reg_write==1, busy[rd] is cleared. This is the same edge on which the register file writes.
  - Same register set and cleared on the same edge: set wins.
  - issue_ok does not bypass a same-cycle clear.
  - Commits to non-busy registers are legal (untracked writes); busy is unaffected.
  - issue_valid with issue_ok=0 is ignored.
- Register 0 is an ordinary register; no special casing.
- Steady state with both sources always valid: count settles at DEPTH-1, mem accepted every cycle, alu stalled. It never overflows.

Test Plan:
1. Reset, single ALU push rd=2 data=0x1E -> reg_write=1 for one cycle, two edges after acceptance, with rd=2 and write_data=0x1E. count returns to 0.
2. Same-cycle mem (rd=3, 0xAA) and ALU (rd=4, 0x55), both accepted -> commits on consecutive cycles: rd=3/0xAA, then rd=4/0x55.
3. DEPTH=4, both sources valid every cycle with incrementing data:
   - count sequence is 0, 2, 3, 3, ...
   - Once count=3, alu_ready=0 while mem_valid=1.
   - Dropping mem_valid makes alu_ready=1.
   - No entry lost or reordered.
4. Issue rd=5 -> busy[5]=1 and issue_ok=0 for issue_rd=5. ALU push rd=5 -> busy[5] clears on the edge where reg_write=1 with rd=5.
5. Commit rd=1 (never issued) on the same edge as issue of rd=1 -> busy[1]=1 after that edge.
6. Assert rst asynchronously with count=3 and busy=0x28:
   - Immediately: reg_write=0, count=0, busy=0, both readies 0.
   - After release, the first new push commits normally with no stale entries.
